// File: rtl/joy_db9_pkg.sv
// Shared types and constants for the DB9 joystick scanner.
// Button bit positions follow the published joy_o layout.
package joy_db9_pkg;

    localparam int JOY_W     = 12;
    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_B     = 4;
    localparam int JOY_C     = 5;
    localparam int JOY_A     = 6;
    localparam int JOY_START = 7;
    localparam int JOY_Z     = 8;
    localparam int JOY_Y     = 9;
    localparam int JOY_X     = 10;
    localparam int JOY_MODE  = 11;

    // Synchronized pin vector layout: R, L, D, U, pin6, pin9
    localparam int PIN_W = 6;

    typedef enum logic [3:0] {
        ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_COMMIT
    } state_e;

    // Select is low only during the odd protocol steps.
    function automatic logic sel_of(state_e s);
        return !(s inside {ST_S1, ST_S3, ST_S5, ST_S7});
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle (pulled-up) pins read released.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/joy_db9_scanner.sv
// DB9 joystick scanner: runs the 8-step Genesis select sequence once per frame and
// publishes a frame-coherent button word. Optional JOY_DEBOUNCE_EN: two-frame agreement.
module joy_db9_scanner
    import joy_db9_pkg::*;
#(
    parameter int STEP_CYCLES  = 500,
    parameter int FRAME_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_en,
    input  logic             joy_up_n,
    input  logic             joy_down_n,
    input  logic             joy_left_n,
    input  logic             joy_right_n,
    input  logic             joy_b1_n,
    input  logic             joy_b2_n,
    output logic             joy_sel_o,
    output logic [JOY_W-1:0] joy_o,
    output logic             pad_present_o,
    output logic             six_btn_o,
    output logic             frame_done_o
);

    localparam int PW = $clog2(FRAME_CYCLES);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [PW-1:0] PER_MAX  = PW'(FRAME_CYCLES - 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);

    logic [PIN_W-1:0] raw_n, sync_n, pin;

    assign raw_n = {joy_b2_n, joy_b1_n, joy_up_n, joy_down_n, joy_left_n, joy_right_n};

    sync_2ff #(.WIDTH(PIN_W)) u_sync (
        .clk  (clk),
        .rst_n(reset_n),
        .d_i  (raw_n),
        .q_o  (sync_n)
    );

    assign pin = ~sync_n;

    state_e           state_q;
    logic [PW-1:0]    per_q;
    logic [SW-1:0]    step_q;
    logic             sel_q;
    logic [5:0]       s0_q;
    logic [1:0]       s1_q;
    logic [3:0]       s6_q;
    logic             det3_q, det6_q;
    logic [JOY_W-1:0] joy_q;
    logic             present_q, six_q, done_q;
    logic [JOY_W-1:0] word_d;
    logic             six_d;
`ifdef JOY_DEBOUNCE_EN
    logic [JOY_W-1:0] cand_q;
`endif

    // Extended buttons only count when the pad proved it speaks the protocol.
    always_comb begin
        six_d  = det3_q & det6_q;
        word_d = {s6_q & {4{six_d}}, s1_q & {2{det3_q}}, s0_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            per_q     <= '0;
            step_q    <= '0;
            sel_q     <= 1'b1;
            s0_q      <= '0;
            s1_q      <= '0;
            s6_q      <= '0;
            det3_q    <= 1'b0;
            det6_q    <= 1'b0;
            joy_q     <= '0;
            present_q <= 1'b0;
            six_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
            cand_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            per_q  <= (per_q == PER_MAX) ? '0 : per_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (per_q == PER_MAX && scan_en) begin
                        state_q <= ST_S0;
                        step_q  <= '0;
                        sel_q   <= 1'b1;
                    end
                end
                ST_COMMIT: begin
`ifdef JOY_DEBOUNCE_EN
                    cand_q <= word_d;
                    if (word_d == cand_q) begin
                        joy_q     <= word_d;
                        present_q <= det3_q;
                        six_q     <= six_d;
                        done_q    <= 1'b1;
                    end
`else
                    joy_q     <= word_d;
                    present_q <= det3_q;
                    six_q     <= six_d;
                    done_q    <= 1'b1;
`endif
                    state_q <= ST_IDLE;
                    sel_q   <= 1'b1;
                end
                default: begin
                    if (step_q == STEP_MAX) begin
                        step_q <= '0;
                        case (state_q)
                            ST_S0: s0_q <= pin;
                            ST_S1: begin
                                s1_q   <= pin[5:4];
                                det3_q <= pin[JOY_L] & pin[JOY_R];
                            end
                            ST_S5: det6_q <= &pin[3:0];
                            ST_S6: s6_q <= {pin[JOY_R], pin[JOY_L], pin[JOY_D], pin[JOY_U]};
                            default: ;
                        endcase
                        state_q <= state_e'(state_q + 4'd1);
                        sel_q   <= sel_of(state_e'(state_q + 4'd1));
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign joy_sel_o     = sel_q;
    assign joy_o         = joy_q;
    assign pad_present_o = present_q;
    assign six_btn_o     = six_q;
    assign frame_done_o  = done_q;

endmodule
